// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-entry issue buffer between decode and the ALU.
// Holds one micro-op and issues it when the memory stage is not blocked.
// After a branch-class op issues, waits one cycle for the ALU's registered
// branch outcome and emits a fetch redirect if the branch was taken.
// After IMUL issues, the multiplier stays busy for MUL_LAT cycles in total.
// Optional feature macro: ALU_ISSUE_PERF_EN adds the issued/stall perf counters.
module alu_issue_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [9:0]  in_opcode,
   input  logic [63:0] in_oprd1,
   input  logic [63:0] in_oprd2,
   input  logic [63:0] in_oprd3,
   input  logic [63:0] in_next_rip,
   input  logic        flush,
   input  logic        mem_blocked,
   output logic        alu_enable,
   output logic [9:0]  alu_opcode,
   output logic [63:0] alu_oprd1,
   output logic [63:0] alu_oprd2,
   output logic [63:0] alu_oprd3,
   output logic [63:0] alu_next_rip,
   input  logic        alu_branch,
   input  logic [63:0] alu_branch_rip,
   output logic        redirect_valid,
   output logic [63:0] redirect_rip,
   output logic        busy
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_issued,
   output logic [CNT_W-1:0] perf_stall
`endif
);

   typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1, MUL_WAIT = 2'd2} state_t;

   localparam logic [9:0] IMUL_OP      = 10'b00_1111_0111;
   localparam logic [3:0] MUL_CNT_LOAD = 4'(MUL_LAT - 1);

   // Reject parameter values the 4-bit occupancy counter cannot represent.
   if (MUL_LAT < 1 || MUL_LAT > 15 || CNT_W < 1) begin : g_bad_param
      $error("alu_issue_ctrl: MUL_LAT must be 1..15 and CNT_W >= 1");
   end

   state_t      state_reg, state_next;
   logic [3:0]  mul_cnt_reg, mul_cnt_next;
   logic        op_v_reg, op_v_next;
   logic [9:0]  opcode_reg;
   logic [63:0] oprd1_reg, oprd2_reg, oprd3_reg, next_rip_reg;
   logic        redirect_valid_reg, redirect_valid_next;
   logic [63:0] redirect_rip_reg, redirect_rip_next;
   logic        fire, accept, op_is_branch, op_is_imul;

   // Branch-class decode: Jcc short/long, CALL rel, JMP rel/short, RET, CALL indirect.
   always_comb begin
      op_is_branch = (opcode_reg[9:4] == 6'b00_0111) ||
                     (opcode_reg[9:4] == 6'b01_1000) ||
                     (opcode_reg == 10'h0E8) || (opcode_reg == 10'h0E9) ||
                     (opcode_reg == 10'h0EB) || (opcode_reg == 10'h0C3) ||
                     (opcode_reg == 10'b11_0001_0000);
      op_is_imul   = (opcode_reg == IMUL_OP);
   end

   // Handshake, issue and next-state logic; flush overrides every transition.
   always_comb begin
      fire                = (state_reg == RUN) && op_v_reg && !mem_blocked && !flush;
      in_ready            = (state_reg == RUN) && !flush && (!op_v_reg || fire);
      accept              = in_valid && in_ready;
      state_next          = state_reg;
      mul_cnt_next        = mul_cnt_reg;
      op_v_next           = op_v_reg;
      redirect_valid_next = 1'b0;
      redirect_rip_next   = redirect_rip_reg;

      if (accept)
         op_v_next = 1'b1;
      else if (fire)
         op_v_next = 1'b0;

      unique case (state_reg)
         RUN: begin
            if (fire && op_is_branch) begin
               state_next = BR_WAIT;
            end else if (fire && op_is_imul && (MUL_LAT > 1)) begin
               state_next   = MUL_WAIT;
               mul_cnt_next = MUL_CNT_LOAD;
            end
         end
         BR_WAIT: begin
            // Branch outcome is registered in the ALU; it is valid now.
            state_next = RUN;
            if (alu_branch) begin
               redirect_valid_next = 1'b1;
               redirect_rip_next   = alu_branch_rip;
               op_v_next           = 1'b0;  // younger op is on the wrong path
            end
         end
         MUL_WAIT: begin
            mul_cnt_next = mul_cnt_reg - 4'd1;
            if (mul_cnt_reg == 4'd1)
               state_next = RUN;
         end
         default: state_next = RUN;
      endcase

      if (flush) begin
         op_v_next           = 1'b0;
         state_next          = RUN;
         mul_cnt_next        = 4'd0;
         redirect_valid_next = 1'b0;
         redirect_rip_next   = redirect_rip_reg;
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg          <= RUN;
         mul_cnt_reg        <= 4'd0;
         op_v_reg           <= 1'b0;
         redirect_valid_reg <= 1'b0;
         redirect_rip_reg   <= 64'd0;
      end else begin
         state_reg          <= state_next;
         mul_cnt_reg        <= mul_cnt_next;
         op_v_reg           <= op_v_next;
         redirect_valid_reg <= redirect_valid_next;
         redirect_rip_reg   <= redirect_rip_next;
      end
   end

   // Holding register payload; only loaded on accept, qualified by op_v_reg.
   always_ff @(posedge clk) begin
      if (accept) begin
         opcode_reg   <= in_opcode;
         oprd1_reg    <= in_oprd1;
         oprd2_reg    <= in_oprd2;
         oprd3_reg    <= in_oprd3;
         next_rip_reg <= in_next_rip;
      end
   end

   assign alu_enable     = fire;
   assign alu_opcode     = opcode_reg;
   assign alu_oprd1      = oprd1_reg;
   assign alu_oprd2      = oprd2_reg;
   assign alu_oprd3      = oprd3_reg;
   assign alu_next_rip   = next_rip_reg;
   assign redirect_valid = redirect_valid_reg;
   assign redirect_rip   = redirect_rip_reg;
   assign busy           = op_v_reg || (state_reg != RUN);

`ifdef ALU_ISSUE_PERF_EN
   logic [CNT_W-1:0] perf_issued_reg, perf_stall_reg;

   // Saturating perf counters; only reset clears them.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_issued_reg <= '0;
         perf_stall_reg  <= '0;
      end else begin
         if (fire && (perf_issued_reg != '1))
            perf_issued_reg <= perf_issued_reg + 1'b1;
         if (op_v_reg && !fire && (perf_stall_reg != '1))
            perf_stall_reg <= perf_stall_reg + 1'b1;
      end
   end

   assign perf_issued = perf_issued_reg;
   assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sits between decode and the ALU; owns the ALU's enable and operand inputs.
- Buffers one micro-op in a holding register and issues it when the memory stage is not blocked.
- Serialises branch-class ops until the ALU's registered branch outcome is known, then emits a fetch redirect.
- Enforces a structural-hazard window after IMUL so the multiplier is not re-entered early.

Parameters:
- MUL_LAT, 4, total IMUL occupancy in cycles; legal 1..15; 1 = no extra stall.
- CNT_W, 32, width of the perf counters (used only under the macro).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  decode offers a micro-op.
- in_ready  out  1  controller accepts; a transfer occurs when in_valid && in_ready.
- in_opcode  in  10  opcode_t micro-op.
- in_oprd1/in_oprd2/in_oprd3  in  64 each  operands.
- in_next_rip  in  64  RIP of the following instruction.
- flush  in  1  pipeline flush; drops any held op.
- mem_blocked  in  1  memory stage stalled; no issue this cycle.
- alu_enable  out  1  ALU enable.
- alu_opcode  out  10  driven from the holding register.
- alu_oprd1/2/3  out  64 each  driven from the holding register.
- alu_next_rip  out  64  driven from the holding register.
- alu_branch  in  1  registered ALU branch flag.
- alu_branch_rip  in  64  registered ALU branch target.
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_rip  out  64  redirect target.
- busy  out  1  op_v || state != RUN.

Behaviour:
- Storage: holding register op_q plus valid bit op_v.
- Reset (reset_n=0 at posedge): op_v=0, state=RUN, mul_cnt=0, redirect_valid=0, redirect_rip=0. Combinational outputs after reset: alu_enable=0, in_ready=1, busy=0.
- ALU operand/opcode/next_rip outputs always equal op_q.
- fire = (state==RUN) && op_v && !mem_blocked && !flush.
- alu_enable = fire; no other condition asserts it.
- in_ready = (state==RUN) && !flush && (!op_v || fire). Sustained throughput is 1 op/cycle for non-branch, non-IMUL ops.
- On accept: op_q <= in_*, op_v <= 1. On fire without accept: op_v <= 0.
- Branch-class opcodes:
  - 10'b00_0111_???? (Jcc short), 10'b01_1000_???? (Jcc long).
  - 0x0E8, 0x0E9, 0x0EB, 0x0C3.
  - 10'b11_0001_0000 (0xFF /2 call).
- IMUL opcode: 10'b00_1111_0111.
- States:
  - RUN:
    - fire of a branch-class op -> BR_WAIT.
    - fire of IMUL with MUL_LAT>1 -> MUL_WAIT, mul_cnt <= MUL_LAT-1.
    - otherwise stay in RUN.
  - BR_WAIT (exactly 1 cycle): in_ready=0, alu_enable=0. Sample alu_branch regardless of mem_blocked.
    - If alu_branch=1: next cycle redirect_valid=1 and redirect_rip=alu_branch_rip; any op_q is invalidated in the same edge; -> RUN.
    - Else -> RUN with no redirect.
    - The op is never re-issued.
  - MUL_WAIT: in_ready=0, alu_enable=0. mul_cnt decrements every cycle, including under mem_blocked. When mul_cnt==1 at the edge, -> RUN.
- redirect_valid is high for exactly one cycle per taken branch; otherwise 0.
- flush (priority below reset, above everything else):
  - op_v <= 0, state <= RUN, mul_cnt <= 0; no issue and no accept that cycle.
  - A redirect due from a BR_WAIT flushed in the same cycle is suppressed.
- Simultaneous fire and accept: the new op enters op_q; the old op is on the ALU inputs this cycle.
- mem_blocked in RUN: hold op_q, alu_enable=0, in_ready = !op_v.
- mul_cnt is 4 bits; there is no wrap-around, because it only loads MUL_LAT-1 ≤ 14.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- When defined:
  - Output perf_issued [CNT_W] increments on each fire.
  - Output perf_stall [CNT_W] increments each cycle op_v && !fire.
  - Both saturate at all-ones and clear only on reset; flush does not clear them.
- When undefined: neither port nor counter logic exists.

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 -> alu_enable=0, in_ready=1, busy=0, redirect_valid=0.
- Back-to-back ADD ops (opcode 0x001, oprds 5 and 7) on 4 consecutive cycles, mem_blocked=0 -> alu_enable high 4 consecutive cycles starting 1 cycle after first accept; in_ready stays 1.
- Op 0x0E9, oprd2=0x10, next_rip=0x400100; ALU returns alu_branch=1, rip=0x400110 -> BR_WAIT 1 cycle; redirect_valid pulse with redirect_rip=0x400110; a younger op accepted earlier is dropped and never enabled.
- IMUL (0x0F7) with MUL_LAT=4, followed by a MOV -> MOV alu_enable occurs exactly 4 cycles after IMUL alu_enable; in_ready=0 for 3 cycles.
- mem_blocked=1 for 3 cycles with op held -> alu_enable=0 throughout, op_q unchanged; op issues the first cycle mem_blocked=0.
- flush asserted during MUL_WAIT and BR_WAIT with alu_branch=1 -> state RUN next cycle, op_v=0, no redirect pulse; with ALU_ISSUE_PERF_EN, perf_issued is unchanged by the flush.
